avg_pool_ctrl: RTL and testbench
================================

# avg_pool_ctrl

Sequencer for the 2x2 average-pooling datapath. On `start` it walks a single-channel IMG_W x IMG_H fp16 feature map held in a synchronous-read buffer, one non-overlapping 2x2 window per step, stride 2. For each window it fetches the four pixels and presents them to the shared four-input fp16 averaging unit (`numA..numD` -> `AvgOut`). It registers the result and writes it to the pooled-output buffer, then signals `done`. The averaging unit stays outside this block; this block owns only addressing, operand staging and write-back.

## Interface
Parameters:
- DATA_WIDTH, 16, fp16 word width
- IMG_W, 28, input map width in pixels (>= 2)
- IMG_H, 28, input map height in pixels (>= 2)
- ADDR_WIDTH, 10, address width of both buffers (must cover IMG_W*IMG_H-1)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin one pooling pass; sampled only in IDLE
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse at end of pass
- rd_en  out  1  input-buffer read strobe
- rd_addr  out  ADDR_WIDTH  input-buffer address, y*IMG_W + x
- rd_data  in  DATA_WIDTH  input-buffer data, valid the cycle after rd_en
- num_a, num_b, num_c, num_d  out  DATA_WIDTH each  operands to averaging unit: top-left, top-right, bottom-left, bottom-right
- avg_in  in  DATA_WIDTH  averaging-unit result (combinational from num_a..num_d)
- wr_en  out  1  output-buffer write strobe
- wr_addr  out  ADDR_WIDTH  output index, row*OW + col
- wr_data  out  DATA_WIDTH  pooled value

## Operation
- Output dimensions are OW = IMG_W/2 and OH = IMG_H/2, with integer floor. For odd dimensions the last input column or row is never read. Window count is N = OW*OH.
- Counters: col (0..OW-1), row (0..OH-1), k (0..3), out_idx (0..N-1). col wraps to 0 and row increments when col = OW-1.
- FSM states:
  - IDLE: all strobes 0. If start = 1, go to FETCH and clear row, col, k and out_idx.
  - FETCH: rd_en = 1. rd_addr offset by k:
    - k=0: (2row, 2col)
    - k=1: (2row, 2col+1)
    - k=2: (2row+1, 2col)
    - k=3: (2row+1, 2col+1)
  - FETCH, capture: rd_data returned for k-1 is captured into operand register k-1. k increments each cycle; after k=3, go to DRAIN.
  - DRAIN: rd_en = 0. Capture rd_data into operand register d. Go to AVG.
  - AVG: operand registers are stable and drive num_a..num_d. Register avg_in into the result register at the end of the cycle. Go to WRITE.
  - WRITE: wr_en = 1, wr_addr = out_idx, wr_data = result register. If out_idx = N-1, go to DONE. Otherwise advance col/row, increment out_idx, clear k and go to FETCH.
  - DONE: done = 1 for this cycle only. Go to IDLE.
- num_a..num_d always reflect the operand registers. They change only on capture cycles.
- start is ignored outside IDLE, including in the DONE cycle. There is no queueing.
- Address arithmetic uses unsigned integers at ADDR_WIDTH. No wrap occurs for legal parameters.

## Timing
- Reset (asynchronous assertion, synchronous-safe release) forces state to IDLE. It also forces busy, done, rd_en and wr_en to 0, and rd_addr, wr_addr, wr_data, num_a..num_d, all counters and the result register to 0.
- Reset mid-pass aborts immediately: no further reads or writes, and done is not pulsed. A new start is required.
- Let cycle 0 be the cycle in which start is sampled in IDLE. Window n (0-based) then occupies cycles 7n+1 .. 7n+7:
  - FETCH on cycles 7n+1..7n+4
  - DRAIN on cycle 7n+5
  - AVG on cycle 7n+6
  - WRITE on cycle 7n+7
- done is high in cycle 7N+1, and busy falls after it. For 28x28, N = 196, so done is in cycle 1373.
- The earliest re-start is sampled in cycle 7N+2.
- Buffer read latency is exactly 1 cycle. wr_en is never high in the same cycle as rd_en.

## Test plan
- Reset: hold reset_n = 0 with start = 1 -> all outputs 0, busy stays 0; release -> still IDLE until start is sampled.
- 4x4 map (IMG_W = IMG_H = 4), window 0 pixels 0x3C00, 0x4000, 0x4200, 0x4400 -> rd_addr sequence 0, 1, 4, 5 on cycles 1..4; wr_addr 0 with wr_data 0x4100 in cycle 7.
- Same 4x4 full pass -> wr_addr 0, 1, 2, 3 in cycles 7, 14, 21, 28; window 3 reads addresses 10, 11, 14, 15; done in cycle 29 only.
- 5x3 map (odd dimensions) -> OW = 2, OH = 1; reads only addresses 0, 1, 5, 6, 2, 3, 7, 8; column 4 and row 2 never read; two writes; done in cycle 15.
- start pulsed in cycles 3, 10 and 29 of a 4x4 pass -> no effect; start in cycle 30 -> new pass with rd_addr 0 in cycle 31.
- reset_n dropped in cycle 12 of a 4x4 pass -> every output 0 immediately; no done pulse; later start gives the normal cycle-1 read of address 0.

Source files
------------

// File: rtl/avg_pool_ctrl.sv
// Address/operand sequencer for 2x2 stride-2 average pooling: fetches each window,
// stages the four operands for the external averaging unit and writes the result back.
module avg_pool_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] num_a,
    output logic [DATA_WIDTH-1:0] num_b,
    output logic [DATA_WIDTH-1:0] num_c,
    output logic [DATA_WIDTH-1:0] num_d,
    input  logic [DATA_WIDTH-1:0] avg_in,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [2:0]            fsm_state
);

    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;
    localparam int N  = OW * OH;

    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(OW - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE     = ADDR_WIDTH'(IMG_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_AVG   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   row;
    logic [ADDR_WIDTH-1:0]   col;
    logic [ADDR_WIDTH-1:0]   out_idx;
    logic [1:0]              k;
    logic [DATA_WIDTH-1:0]   result;
    logic [ADDR_WIDTH-1:0]   nxt_row;
    logic [ADDR_WIDTH-1:0]   nxt_col;

    // Pixel address of tap kk (bit1 = lower row, bit0 = right column) of window (r, c).
    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] r,
                                                      input logic [ADDR_WIDTH-1:0] c,
                                                      input logic [1:0]            kk);
        logic [ADDR_WIDTH-1:0] y;
        logic [ADDR_WIDTH-1:0] x;
        y = (r << 1) + ADDR_WIDTH'(kk[1]);
        x = (c << 1) + ADDR_WIDTH'(kk[0]);
        return (y * LINE) + x;
    endfunction

    always_comb begin
        nxt_row = row;
        nxt_col = col + 1'b1;
        if (col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = row + 1'b1;
        end
    end

    assign wr_data   = result;
    assign fsm_state = state;

    // Outputs are registered: each transition loads the strobes/addresses of the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            num_a   <= '0;
            num_b   <= '0;
            num_c   <= '0;
            num_d   <= '0;
            result  <= '0;
            row     <= '0;
            col     <= '0;
            out_idx <= '0;
            k       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        row     <= '0;
                        col     <= '0;
                        out_idx <= '0;
                        k       <= '0;
                    end
                end
                S_FETCH: begin
                    // Data arriving now belongs to the read issued for tap k-1.
                    case (k)
                        2'd1:    num_a <= rd_data;
                        2'd2:    num_b <= rd_data;
                        2'd3:    num_c <= rd_data;
                        default: ;
                    endcase
                    if (k == 2'd3) begin
                        state <= S_DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        k       <= k + 2'd1;
                        rd_addr <= addr_of(row, col, k + 2'd1);
                    end
                end
                S_DRAIN: begin
                    num_d <= rd_data;
                    state <= S_AVG;
                end
                S_AVG: begin
                    result  <= avg_in;
                    wr_en   <= 1'b1;
                    wr_addr <= out_idx;
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    wr_en <= 1'b0;
                    if (out_idx == IDX_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= S_FETCH;
                        row     <= nxt_row;
                        col     <= nxt_col;
                        out_idx <= out_idx + 1'b1;
                        k       <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= addr_of(nxt_row, nxt_col, 2'd0);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avg_pool_ctrl.sv
// Bench for avg_pool_ctrl: a 4x4 and a 5x3 instance, each with a one-cycle-latency
// buffer model and a behavioural fp16 averager, checked against hand-computed window tables.
module tb_avg_pool_ctrl;

    localparam int DW = 16;
    localparam int AW = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- DUT signals ----------------
    logic          start4, busy4, done4, rd_en4, wr_en4;
    logic [AW-1:0] rd_addr4, wr_addr4;
    logic [DW-1:0] rd_data4 = '0, na4, nb4, nc4, nd4, avg4, wr_data4;
    logic [2:0]    st4;
    logic          start53, busy53, done53, rd_en53, wr_en53;
    logic [AW-1:0] rd_addr53, wr_addr53;
    logic [DW-1:0] rd_data53 = '0, na53, nb53, nc53, nd53, avg53, wr_data53;
    logic [2:0]    st53;

    assign start4  = start & ~sel;
    assign start53 = start & sel;

    avg_pool_ctrl #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4), .ADDR_WIDTH(AW)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .num_a(na4), .num_b(nb4), .num_c(nc4), .num_d(nd4), .avg_in(avg4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .fsm_state(st4)
    );

    avg_pool_ctrl #(.DATA_WIDTH(DW), .IMG_W(5), .IMG_H(3), .ADDR_WIDTH(AW)) u_dut53 (
        .clk(clk), .reset_n(reset_n), .start(start53), .busy(busy53), .done(done53),
        .rd_en(rd_en53), .rd_addr(rd_addr53), .rd_data(rd_data53),
        .num_a(na53), .num_b(nb53), .num_c(nc53), .num_d(nd53), .avg_in(avg53),
        .wr_en(wr_en53), .wr_addr(wr_addr53), .wr_data(wr_data53), .fsm_state(st53)
    );

    // ---------------- buffers and averaging unit ----------------
    logic [DW-1:0] mem4  [1024];
    logic [DW-1:0] mem53 [1024];

    always @(posedge clk) if (rd_en4)  rd_data4  <= mem4[rd_addr4];
    always @(posedge clk) if (rd_en53) rd_data53 <= mem53[rd_addr53];

    function automatic real fp16_to_real(input logic [15:0] h);
        int  e;
        real s;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        s = 1.0 + real'(h[9:0]) / 1024.0;
        while (e > 15) begin s = s * 2.0; e--; end
        while (e < 15) begin s = s / 2.0; e++; end
        return s;
    endfunction

    function automatic logic [15:0] real_to_fp16(input real v);
        int e;
        int m;
        if (v <= 0.0) return 16'h0000;
        e = 15;
        while (v >= 2.0 && e < 30) begin v = v / 2.0; e++; end
        while (v < 1.0 && e > 1) begin v = v * 2.0; e--; end
        m = $rtoi((v - 1.0) * 1024.0 + 0.5);
        if (m > 1023) begin m = 0; e++; end
        return {1'b0, 5'(e), 10'(m)};
    endfunction

    function automatic logic [15:0] fp16_avg(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c, input logic [15:0] d);
        return real_to_fp16((fp16_to_real(a) + fp16_to_real(b) + fp16_to_real(c) + fp16_to_real(d)) / 4.0);
    endfunction

    always_comb avg4  = fp16_avg(na4, nb4, nc4, nd4);
    always_comb avg53 = fp16_avg(na53, nb53, nc53, nd53);

    // ---------------- observation mux ----------------
    logic          o_busy, o_done, o_rd_en, o_wr_en;
    logic [AW-1:0] o_rd_addr, o_wr_addr;
    logic [DW-1:0] o_na, o_nb, o_nc, o_nd, o_wr_data;
    always_comb begin
        o_busy    = sel ? busy53    : busy4;
        o_done    = sel ? done53    : done4;
        o_rd_en   = sel ? rd_en53   : rd_en4;
        o_wr_en   = sel ? wr_en53   : wr_en4;
        o_rd_addr = sel ? rd_addr53 : rd_addr4;
        o_wr_addr = sel ? wr_addr53 : wr_addr4;
        o_wr_data = sel ? wr_data53 : wr_data4;
        o_na      = sel ? na53      : na4;
        o_nb      = sel ? nb53      : nb4;
        o_nc      = sel ? nc53      : nc4;
        o_nd      = sel ? nd53      : nd4;
    end

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [3:0][15:0] pix;
        logic [3:0][9:0]  addr;
        logic [9:0]       wr_addr;
        logic [15:0]      wr_data;
    } win_t;

    win_t tbl [6];

    task automatic set_win(input int i,
                           input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3,
                           input int a0, input int a1, input int a2, input int a3,
                           input int wa, input logic [15:0] wd);
        tbl[i].pix[0] = p0;  tbl[i].pix[1] = p1;  tbl[i].pix[2] = p2;  tbl[i].pix[3] = p3;
        tbl[i].addr[0] = 10'(a0); tbl[i].addr[1] = 10'(a1);
        tbl[i].addr[2] = 10'(a2); tbl[i].addr[3] = 10'(a3);
        tbl[i].wr_addr = 10'(wa);
        tbl[i].wr_data = wd;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard: expected {wr_addr, wr_data} per window, popped on every observed write.
    logic [25:0] exp_q[$];

    always @(negedge clk) begin
        if (o_wr_en) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write @%0t: got addr %0h data %0h expected no write",
                         $time, o_wr_addr, o_wr_data);
            end else begin
                logic [25:0] e;
                e = exp_q.pop_front();
                chk("write", 32'({o_wr_addr, o_wr_data}), 32'(e));
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},    32'(o_busy),    32'(0));
        chk({tag, "_done"},    32'(o_done),    32'(0));
        chk({tag, "_rd_en"},   32'(o_rd_en),   32'(0));
        chk({tag, "_rd_addr"}, 32'(o_rd_addr), 32'(0));
        chk({tag, "_wr_en"},   32'(o_wr_en),   32'(0));
        chk({tag, "_wr_addr"}, 32'(o_wr_addr), 32'(0));
        chk({tag, "_wr_data"}, 32'(o_wr_data), 32'(0));
        chk({tag, "_num_a"},   32'(o_na),      32'(0));
        chk({tag, "_num_b"},   32'(o_nb),      32'(0));
        chk({tag, "_num_c"},   32'(o_nc),      32'(0));
        chk({tag, "_num_d"},   32'(o_nd),      32'(0));
    endtask

    // Expected outputs in cycle c (1-based, cycle 0 = start sampled) of a pass.
    task automatic chk_cycle(input int first, input int nwin, input int c);
        int n;
        int ph;
        n  = (c - 1) / 7;
        ph = (c - 1) % 7;
        chk("busy", 32'(o_busy), 32'(1));
        if (c == 7 * nwin + 1) begin
            chk("done",    32'(o_done),  32'(1));
            chk("rd_en_d", 32'(o_rd_en), 32'(0));
            chk("wr_en_d", 32'(o_wr_en), 32'(0));
        end else begin
            chk("done",  32'(o_done),  32'(0));
            chk("rd_en", 32'(o_rd_en), 32'(ph < 4));
            chk("wr_en", 32'(o_wr_en), 32'(ph == 6));
            if (ph < 4) chk("rd_addr", 32'(o_rd_addr), 32'(tbl[first + n].addr[ph]));
            if (ph == 5) begin
                chk("num_a", 32'(o_na), 32'(tbl[first + n].pix[0]));
                chk("num_b", 32'(o_nb), 32'(tbl[first + n].pix[1]));
                chk("num_c", 32'(o_nc), 32'(tbl[first + n].pix[2]));
                chk("num_d", 32'(o_nd), 32'(tbl[first + n].pix[3]));
            end
        end
    endtask

    // Called at the negedge of cycle 0; returns at the negedge of cycle 7N+2 (idle).
    task automatic run_pass(input int first, input int nwin, input bit inject);
        start = 1'b1;
        chk("idle_busy", 32'(o_busy), 32'(0));
        for (int i = 0; i < nwin; i++)
            exp_q.push_back({tbl[first + i].wr_addr, tbl[first + i].wr_data});
        for (int c = 1; c <= 7 * nwin + 1; c++) begin
            @(negedge clk);
            start = inject && (c == 3 || c == 10 || c == 29);
            chk_cycle(first, nwin, c);
        end
        @(negedge clk);
        start = 1'b0;
        chk("post_busy",  32'(o_busy),  32'(0));
        chk("post_done",  32'(o_done),  32'(0));
        chk("post_rd_en", 32'(o_rd_en), 32'(0));
        chk("post_wr_en", 32'(o_wr_en), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        set_win(0, 16'h3C00, 16'h4000, 16'h4200, 16'h4400,  0,  1,  4,  5, 0, 16'h4100);
        set_win(1, 16'h4400, 16'h4400, 16'h4800, 16'h4800,  2,  3,  6,  7, 1, 16'h4600);
        set_win(2, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4500,  8,  9, 12, 13, 2, 16'h4000);
        set_win(3, 16'h3800, 16'h3C00, 16'h3E00, 16'h3C00, 10, 11, 14, 15, 3, 16'h3C00);
        set_win(4, 16'h4000, 16'h4400, 16'h4600, 16'h4800,  0,  1,  5,  6, 0, 16'h4500);
        set_win(5, 16'h4200, 16'h4200, 16'h3C00, 16'h3C00,  2,  3,  7,  8, 1, 16'h4000);
        for (int i = 0; i < 1024; i++) begin
            mem4[i]  = 16'h3C00;
            mem53[i] = 16'h7BFF;
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) mem4[tbl[i].addr[j]] = tbl[i].pix[j];
        for (int i = 4; i < 6; i++)
            for (int j = 0; j < 4; j++) mem53[tbl[i].addr[j]] = tbl[i].pix[j];

        // Reset held with start asserted.
        reset_n = 1'b0;
        start   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_zero("rst");
        end
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rel_busy",  32'(o_busy),  32'(0));
            chk("rel_rd_en", 32'(o_rd_en), 32'(0));
        end

        // 4x4 pass with stray starts, then back-to-back re-start in cycle 30.
        run_pass(0, 4, 1'b1);
        run_pass(0, 4, 1'b0);

        // Abort in cycle 12 (window 1 drain).
        start = 1'b1;
        exp_q.push_back({tbl[0].wr_addr, tbl[0].wr_data});
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk_cycle(0, 4, c);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_zero("abort");
        repeat (4) begin
            @(negedge clk);
            chk_zero("abort_hold");
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_idle_busy", 32'(o_busy), 32'(0));
            chk("abort_idle_done", 32'(o_done), 32'(0));
        end
        run_pass(0, 4, 1'b0);

        // 5x3 map: odd width and height.
        sel = 1'b1;
        @(negedge clk);
        run_pass(4, 2, 1'b0);

        chk("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
